// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral with a small writable/readable register file.
// Frame on copi: R/W bit (1 = write), address, data, all MSB-first.
module spi_regfile_peripheral #(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ncs,
    input  logic                       sclk,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);

    localparam int unsigned HDR_LEN   = 1 + ADDR_W;
    localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 2);

    logic [2:0]           ncs_s;
    logic [2:0]           sclk_s;
    logic [1:0]           copi_s;
    logic [CNT_W-1:0]     cnt;
    logic [FRAME_LEN-1:0] sh;
    logic [DATA_W-1:0]    out_sh;
    logic                 rd_mode;

    logic                 ncs_fall;
    logic                 ncs_rise;
    logic                 sclk_rise;
    logic                 sclk_fall;
    logic                 active;
    logic [FRAME_LEN-1:0] sh_nx;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_rw;
    logic [DATA_W-1:0]    rd_val;
    logic                 wr_rw;
    logic [ADDR_W-1:0]    wr_fld_addr;
    logic [DATA_W-1:0]    wr_fld_data;
    logic                 commit_c;

    // Pin synchronisers; the extra ncs/sclk stage feeds edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_s  <= '0;
            sclk_s <= '0;
            copi_s <= '0;
        end else begin
            ncs_s  <= {ncs_s[1:0], ncs};
            sclk_s <= {sclk_s[1:0], sclk};
            copi_s <= {copi_s[0], copi};
        end
    end

    assign ncs_fall  = ~ncs_s[1] &  ncs_s[2];
    assign ncs_rise  =  ncs_s[1] & ~ncs_s[2];
    assign sclk_rise =  sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] &  sclk_s[2];
    assign active    = ~ncs_s[1];

    // Header as it will look once the incoming bit is shifted in
    assign sh_nx   = {sh[FRAME_LEN-2:0], copi_s[1]};
    assign rd_addr = sh_nx[ADDR_W-1:0];
    assign rd_rw   = sh_nx[ADDR_W];

    assign wr_rw       = sh[FRAME_LEN-1];
    assign wr_fld_addr = sh[FRAME_LEN-2 -: ADDR_W];
    assign wr_fld_data = sh[DATA_W-1:0];

    assign commit_c = ncs_rise && (cnt == CNT_W'(FRAME_LEN)) && wr_rw
                      && (32'(wr_fld_addr) < NUM_REGS);

    // Read mux; addresses beyond the register file read as zero
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_val = regs_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Frame receive and read-data shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sh      <= '0;
            out_sh  <= '0;
            rd_mode <= 1'b0;
        end else if (ncs_fall) begin
            cnt     <= '0;
            sh      <= '0;
            out_sh  <= '0;
            rd_mode <= 1'b0;
        end else if (ncs_rise) begin
            out_sh  <= '0;
            rd_mode <= 1'b0;
        end else if (active) begin
            if (sclk_rise && (cnt != CNT_W'(FRAME_LEN + 1))) begin
                cnt <= cnt + CNT_W'(1);
                if (cnt < CNT_W'(FRAME_LEN)) begin
                    sh <= sh_nx;
                end
                if ((cnt == CNT_W'(ADDR_W)) && !rd_rw) begin
                    rd_mode <= 1'b1;
                    out_sh  <= rd_val;
                end
            end
            // MSB is presented at load; shift only after a data bit was clocked
            if (sclk_fall && rd_mode && (cnt > CNT_W'(HDR_LEN))
                && (cnt <= CNT_W'(FRAME_LEN))) begin
                out_sh <= out_sh << 1;
            end
        end
    end

    // Write commit on the detected ncs rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_flat <= '0;
            wr_addr   <= '0;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= commit_c;
            if (commit_c) begin
                wr_addr <= wr_fld_addr;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (wr_fld_addr == ADDR_W'(i)) begin
                        regs_flat[i*DATA_W +: DATA_W] <= wr_fld_data;
                    end
                end
            end
        end
    end

    assign cipo    = out_sh[DATA_W-1];
    assign cipo_oe = rd_mode;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench: default-width instance (5x8b, 7b addr) and a scaled one (16x16b, 4b addr).
module tb_spi_regfile_peripheral;

    logic clk = 1'b0;
    logic rst_n;
    logic ncs, sclk, copi;
    logic sel;

    logic         ncs0, sclk0, copi0, cipo0, oe0, strb0;
    logic [39:0]  flat0;
    logic [6:0]   wa0;
    logic         ncs1, sclk1, copi1, cipo1, oe1, strb1;
    logic [255:0] flat1;
    logic [3:0]   wa1;

    logic         cipo_m, oe_m, strb_m;
    logic [255:0] flat_m;
    logic [7:0]   wa_m;

    logic [63:0]  cipo_hist, oe_hist;
    logic [5:0]   strb_hist;
    logic [255:0] flat_at2, flat_at3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign ncs0  = sel ? 1'b1 : ncs;
    assign sclk0 = sel ? 1'b0 : sclk;
    assign copi0 = sel ? 1'b0 : copi;
    assign ncs1  = sel ? ncs  : 1'b1;
    assign sclk1 = sel ? sclk : 1'b0;
    assign copi1 = sel ? copi : 1'b0;

    assign cipo_m = sel ? cipo1 : cipo0;
    assign oe_m   = sel ? oe1   : oe0;
    assign strb_m = sel ? strb1 : strb0;
    assign flat_m = sel ? flat1 : 256'(flat0);
    assign wa_m   = sel ? 8'(wa1) : 8'(wa0);

    spi_regfile_peripheral #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ncs(ncs0), .sclk(sclk0), .copi(copi0),
        .cipo(cipo0), .cipo_oe(oe0), .regs_flat(flat0), .wr_strobe(strb0), .wr_addr(wa0)
    );

    spi_regfile_peripheral #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ncs(ncs1), .sclk(sclk1), .copi(copi1),
        .cipo(cipo1), .cipo_oe(oe1), .regs_flat(flat1), .wr_strobe(strb1), .wr_addr(wa1)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        cipo_hist = '0;
        oe_hist   = '0;
        ncs = 1'b0;
        clks(6);
    endtask

    // Mode 0: copi set while sclk low, cipo sampled just before each rising edge
    task automatic send_bits(input int n, input logic [63:0] bits);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            clks(6);
            cipo_hist = {cipo_hist[62:0], cipo_m};
            oe_hist   = {oe_hist[62:0], oe_m};
            sclk = 1'b1;
            clks(6);
            sclk = 1'b0;
        end
    endtask

    // Raise ncs and record the strobe for the following 6 clk edges
    task automatic frame_end();
        clks(4);
        ncs = 1'b1;
        strb_hist = '0;
        for (int c = 0; c < 6; c++) begin
            clks(1);
            strb_hist = {strb_hist[4:0], strb_m};
            if (c == 1) flat_at2 = flat_m;
            if (c == 2) flat_at3 = flat_m;
        end
        clks(2);
    endtask

    task automatic xfer(input int n, input logic [63:0] bits);
        frame_start();
        send_bits(n, bits);
        frame_end();
    endtask

    logic [255:0] exp1;

    initial begin
        rst_n = 1'b0;
        ncs   = 1'b1;
        sclk  = 1'b0;
        copi  = 1'b0;
        sel   = 1'b0;
        clks(3);
        chk("rst_flat", flat_m, '0);
        chk("rst_cipo", 256'(cipo_m), '0);
        chk("rst_oe", 256'(oe_m), '0);
        chk("rst_strobe", 256'(strb_m), '0);
        chk("rst_wr_addr", 256'(wa_m), '0);
        rst_n = 1'b1;
        clks(6);

        // Write 0xA5 to addr 2: lands on the 3rd clk after ncs rises
        xfer(16, 64'({1'b1, 7'd2, 8'hA5}));
        chk("w2_strobe_hist", 256'(strb_hist), 256'(6'b001000));
        chk("w2_flat_clk2", flat_at2, '0);
        chk("w2_flat_clk3", flat_at3, 256'(40'h00_00_A5_00_00));
        chk("w2_wr_addr", 256'(wa_m), 256'(2));
        chk("w2_oe_hist", 256'(oe_hist), '0);

        // Write 0x3C to addr 1, then read it back
        xfer(16, 64'({1'b1, 7'd1, 8'h3C}));
        chk("w1_flat", flat_m, 256'(40'h00_00_A5_3C_00));
        xfer(16, 64'({1'b0, 7'd1, 8'h00}));
        chk("r1_cipo", 256'(cipo_hist), 256'(16'h003C));
        chk("r1_oe_hist", 256'(oe_hist), 256'(16'h00FF));
        chk("r1_strobe_hist", 256'(strb_hist), '0);
        chk("r1_oe_after", 256'(oe_m), '0);
        chk("r1_cipo_after", 256'(cipo_m), '0);

        // Short and overlong frames commit nothing
        xfer(15, 64'({1'b1, 7'd0, 7'h7F}));
        chk("short_strobe", 256'(strb_hist), '0);
        chk("short_flat", flat_m, 256'(40'h00_00_A5_3C_00));
        xfer(17, 64'({1'b1, 7'd0, 8'hFF, 1'b1}));
        chk("long_strobe", 256'(strb_hist), '0);
        chk("long_flat", flat_m, 256'(40'h00_00_A5_3C_00));

        // Out-of-range address
        xfer(16, 64'({1'b1, 7'd5, 8'h77}));
        chk("oor_strobe", 256'(strb_hist), '0);
        chk("oor_flat", flat_m, 256'(40'h00_00_A5_3C_00));
        chk("oor_wr_addr", 256'(wa_m), 256'(1));
        xfer(16, 64'({1'b0, 7'd5, 8'h00}));
        chk("oor_rd_cipo", 256'(cipo_hist), '0);
        chk("oor_rd_oe", 256'(oe_hist), 256'(16'h00FF));

        // Scaled instance: 21-bit frames
        sel = 1'b1;
        clks(6);
        xfer(21, 64'({1'b1, 4'd2, 16'hA5C3}));
        exp1 = 256'(16'hA5C3) << 32;
        chk("s_w2_strobe_hist", 256'(strb_hist), 256'(6'b001000));
        chk("s_w2_flat_clk2", flat_at2, '0);
        chk("s_w2_flat_clk3", flat_at3, exp1);
        chk("s_w2_wr_addr", 256'(wa_m), 256'(2));
        xfer(21, 64'({1'b1, 4'd1, 16'h3C96}));
        exp1 = exp1 | (256'(16'h3C96) << 16);
        chk("s_w1_flat", flat_m, exp1);
        xfer(21, 64'({1'b0, 4'd1, 16'h0000}));
        chk("s_r1_cipo", 256'(cipo_hist), 256'(16'h3C96));
        chk("s_r1_oe_hist", 256'(oe_hist), 256'(16'hFFFF));
        chk("s_r1_oe_after", 256'(oe_m), '0);
        xfer(21, 64'({1'b1, 4'd15, 16'hBEEF}));
        exp1 = exp1 | (256'(16'hBEEF) << 240);
        chk("s_w15_flat", flat_m, exp1);
        chk("s_w15_wr_addr", 256'(wa_m), 256'(15));

        // Reset after 9 bits of a write aborts the frame
        sel = 1'b0;
        clks(6);
        frame_start();
        send_bits(9, 64'({1'b1, 7'd3, 8'h55}) >> 7);
        rst_n = 1'b0;
        clks(2);
        chk("mid_rst_flat", flat_m, '0);
        chk("mid_rst_oe", 256'(oe_m), '0);
        chk("mid_rst_cipo", 256'(cipo_m), '0);
        chk("mid_rst_strobe", 256'(strb_m), '0);
        chk("mid_rst_wr_addr", 256'(wa_m), '0);
        rst_n = 1'b1;
        clks(2);
        send_bits(7, 64'({1'b1, 7'd3, 8'h55}));
        frame_end();
        chk("mid_rst_no_commit", 256'(strb_hist), '0);
        chk("mid_rst_flat_after", flat_m, '0);
        xfer(16, 64'({1'b1, 7'd4, 8'h11}));
        chk("post_rst_flat", flat_m, 256'(40'h11_00_00_00_00));
        chk("post_rst_strobe", 256'(strb_hist), 256'(6'b001000));
        chk("post_rst_wr_addr", 256'(wa_m), 256'(4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_regfile_peripheral.md
SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

Interface
REQ-001 Parameter NUM_REGS, default 5, number of writable/readable registers (1..2**ADDR_W).
REQ-002 Parameter DATA_W, default 8, register and data-phase width in bits (1..32).
REQ-003 Parameter ADDR_W, default 7, address field width in bits (1..8).
REQ-004 Port clk  input  1  system clock; all state on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port ncs  input  1  SPI chip select, active low, asynchronous to clk.
REQ-007 Port sclk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-008 Port copi  input  1  controller-out/peripheral-in serial data.
REQ-009 Port cipo  output  1  peripheral-out/controller-in serial data.
REQ-010 Port cipo_oe  output  1  high while cipo is driven.
REQ-011 Port regs_flat  output  NUM_REGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].
REQ-012 Port wr_strobe  output  1  one-clk pulse on each committed write.
REQ-013 Port wr_addr  output  ADDR_W  address of the last committed write.

Function
REQ-014 ncs, sclk and copi each pass through a 2-flop synchroniser; a third flop on ncs and sclk provides edge detection (edge = stage2 vs stage3).
REQ-015 Frame = FRAME_LEN = 1+ADDR_W+DATA_W bits, MSB-first on copi: bit 1 R/W (1 = write), then address, then data.
REQ-016 copi is sampled at each synchronised sclk rising edge while synchronised ncs is low.
REQ-017 Synchronised ncs falling edge clears the bit counter, shift register and read-mode flag; it takes priority over a coincident sclk edge.
REQ-018 Bit counter saturates at FRAME_LEN+1; bits beyond FRAME_LEN are ignored and mark the frame overlong.
REQ-019 Write commit occurs on the clk edge detecting a synchronised ncs rising edge, only if count == FRAME_LEN exactly, R/W = 1 and address < NUM_REGS.
REQ-020 On commit: addressed register <= data field, wr_addr <= address, wr_strobe = 1 for exactly that one clk; other registers unchanged.
REQ-021 Short, overlong, out-of-range or read frames commit nothing and assert no strobe.
REQ-022 Read: when count reaches 1+ADDR_W with R/W = 0, the addressed register (or all-zeros if address >= NUM_REGS) loads a DATA_W output shift register.
REQ-023 In read mode, cipo = shift-register MSB; the register shifts left by one on each synchronised sclk falling edge until DATA_W bits are sent.
REQ-024 cipo_oe is high from the load clk until synchronised ncs rises; cipo = 0 whenever cipo_oe = 0.
REQ-025 Write latency: regs_flat updates at the 3rd rising clk edge after the ncs pin rises (setup met).
REQ-026 Back-to-back frames are supported with ncs high for >= 4 clk cycles and sclk half-period >= 4 clk cycles.
REQ-027 A write and a read of the same register in consecutive frames returns the newly written value.

Reset
REQ-028 rst_n low asynchronously clears all synchroniser flops, counter, shift registers, regs_flat, wr_addr, wr_strobe, cipo and cipo_oe to 0.
REQ-029 A reset asserted mid-frame aborts the frame; no partial commit occurs after release, and the next ncs falling edge starts a fresh frame.

Verification
REQ-030 Write 0xA5 to addr 2 (16-bit frame) -> regs_flat[23:16] = 0xA5 at 3rd clk after ncs rises; wr_strobe one cycle; wr_addr = 2.
REQ-031 Write addr 1 = 0x3C, then read addr 1 -> cipo shifts 0x3C MSB-first on the 8 data-phase falling edges; cipo_oe high only during the read frame.
REQ-032 15-bit frame and 17-bit frame, each writing 0xFF to addr 0 -> regs_flat unchanged, no wr_strobe.
REQ-033 Write to addr 5 (out of range, NUM_REGS = 5) -> no change, no strobe; read of addr 5 -> cipo returns 0x00.
REQ-034 rst_n pulsed low after 9 bits of a write -> all outputs 0; following full write of 0x11 to addr 4 -> regs_flat[39:32] = 0x11.
REQ-035 Re-run REQ-030/031 with NUM_REGS = 16, DATA_W = 16, ADDR_W = 4 (21-bit frame) -> same behaviour at the scaled widths.
